// File: rtl/sprite_pkg.sv
// Sprite entry layout, scanner state encoding and the descriptor handed to the line drawer.
package sprite_pkg;

  localparam int BUF_AW = 9;

  // Word offsets within a 4-word sprite entry
  localparam int W_POS  = 0;
  localparam int W_CODE = 1;
  localparam int W_ATTR = 2;
  localparam int W_X    = 3;

  // Field positions inside those words
  localparam int Y_LSB     = 0;
  localparam int Y_MSB     = 8;
  localparam int HC_LSB    = 12;
  localparam int HC_MSB    = 13;
  localparam int COLOR_LSB = 0;
  localparam int COLOR_MSB = 3;
  localparam int FLIPX_BIT = 10;
  localparam int FLIPY_BIT = 11;
  localparam int X_LSB     = 0;
  localparam int X_MSB     = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DMA,
    ST_RD,
    ST_EVAL,
    ST_EMIT
  } scan_state_t;

  typedef struct packed {
    logic [15:0] code;
    logic [3:0]  row;
    logic [9:0]  x;
    logic [3:0]  color;
    logic        flipx;
  } sprite_desc_t;

  function automatic logic [8:0] sprite_height(input logic [1:0] hc);
    return 9'd16 << hc;
  endfunction

endpackage

// File: rtl/dpramv.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle of latency.
module dpramv #(
  parameter int WIDTH = 16,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] q_b
);

  logic [WIDTH-1:0] mem_reg [2**AW];
  logic [WIDTH-1:0] q_b_reg;

  always_ff @(posedge clk) begin
    if (we_a) begin
      mem_reg[addr_a] <= data_a;
    end
    q_b_reg <= mem_reg[addr_b];
  end

  assign q_b = q_b_reg;

endmodule

// File: rtl/sprite_buf.sv
// Private 512x16 sprite buffer: the DMA copy writes on port A, the line scan reads on port B.
module sprite_buf
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [BUF_AW-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [BUF_AW-1:0] rd_addr,
  output logic [15:0]       rd_data
);

  dpramv #(
    .WIDTH (16),
    .AW    (BUF_AW)
  ) u_ram (
    .clk    (clk),
    .we_a   (wr_en),
    .addr_a (wr_addr),
    .data_a (wr_data),
    .addr_b (rd_addr),
    .q_b    (rd_data)
  );

endmodule

// File: rtl/sprite_scan.sv
// Snapshots the CPU sprite RAM on request, then walks the snapshot once per line
// and emits a descriptor for every sprite covering that line.
module sprite_scan
  import sprite_pkg::*;
#(
  parameter int NUM_ENTRIES  = 128,
  parameter int MAX_PER_LINE = 32
) (
  input  logic        CLK_32M,
  input  logic        RESET,
  input  logic        DMA_START,
  output logic [8:0]  RAM_ADDR,
  input  logic [15:0] RAM_DATA,
  output logic        DMA_BUSY,
  input  logic        LINE_START,
  input  logic [8:0]  LINE_V,
  output logic        SCAN_BUSY,
  output logic        LINE_OVERRUN,
  output logic        LINE_FULL,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] OUT_CODE,
  output logic [3:0]  OUT_ROW,
  output logic [9:0]  OUT_X,
  output logic [3:0]  OUT_COLOR,
  output logic        OUT_FLIPX
);

  localparam int ENTRY_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W   = $clog2(MAX_PER_LINE + 1);

  scan_state_t        state_reg;
  logic [9:0]         dma_cnt_reg;
  logic [8:0]         ram_addr_reg;
  logic               dma_busy_reg;
  logic               scan_busy_reg;
  logic               overrun_reg;
  logic               full_reg;
  logic               valid_reg;
  sprite_desc_t       desc_reg;
  logic [ENTRY_W-1:0] entry_reg;
  logic [2:0]         rd_cnt_reg;
  logic [CNT_W-1:0]   emit_cnt_reg;
  logic [8:0]         line_reg;

  logic               buf_wr_en;
  logic [BUF_AW-1:0]  buf_wr_addr;
  logic [BUF_AW-1:0]  buf_rd_addr;
  logic [15:0]        buf_rd_data;
  logic [15:0]        word_reg [4];

  // Word n arrives one cycle after its address, so the write trails the counter by one;
  // the 9-bit wrap makes the final trailing cycle (count 512) land on address 511.
  assign buf_wr_en   = (state_reg == ST_DMA) && (dma_cnt_reg != 10'd0);
  assign buf_wr_addr = dma_cnt_reg[8:0] - 9'd1;
  assign buf_rd_addr = BUF_AW'({entry_reg, rd_cnt_reg[1:0]});

  sprite_buf u_buf (
    .clk     (CLK_32M),
    .wr_en   (buf_wr_en),
    .wr_addr (buf_wr_addr),
    .wr_data (RAM_DATA),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_word
    logic [15:0] word_q;
    always_ff @(posedge CLK_32M) begin
      if (state_reg == ST_RD && rd_cnt_reg == 3'(gi + 1)) begin
        word_q <= buf_rd_data;
      end
    end
    assign word_reg[gi] = word_q;
  end

  logic [8:0]   y_next;
  logic [1:0]   hc_next;
  logic [8:0]   height_next;
  logic [8:0]   dy_next;
  logic [8:0]   row_next;
  logic         hit_next;
  sprite_desc_t desc_next;
  logic         unused_bits;

  always_comb begin
    y_next      = word_reg[W_POS][Y_MSB:Y_LSB];
    hc_next     = word_reg[W_POS][HC_MSB:HC_LSB];
    height_next = sprite_height(hc_next);
    dy_next     = line_reg - y_next;
    hit_next    = dy_next < height_next;
    row_next    = word_reg[W_ATTR][FLIPY_BIT] ? (height_next - 9'd1 - dy_next) : dy_next;
    desc_next.code  = word_reg[W_CODE] + 16'(row_next[6:4]);
    desc_next.row   = row_next[3:0];
    desc_next.x     = word_reg[W_X][X_MSB:X_LSB];
    desc_next.color = word_reg[W_ATTR][COLOR_MSB:COLOR_LSB];
    desc_next.flipx = word_reg[W_ATTR][FLIPX_BIT];
  end

  // Entry bits with no meaning in the entry format, plus row bits above the tallest sprite
  assign unused_bits = ^{word_reg[W_POS][15:14], word_reg[W_POS][11:9],
                         word_reg[W_ATTR][15:12], word_reg[W_ATTR][9:4],
                         word_reg[W_X][15:10], row_next[8:7]};

  logic last_entry;
  assign last_entry = (entry_reg == ENTRY_W'(NUM_ENTRIES - 1));

  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      state_reg     <= ST_IDLE;
      dma_cnt_reg   <= '0;
      ram_addr_reg  <= '0;
      dma_busy_reg  <= 1'b0;
      scan_busy_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      full_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      desc_reg      <= '0;
      entry_reg     <= '0;
      rd_cnt_reg    <= '0;
      emit_cnt_reg  <= '0;
      line_reg      <= '0;
    end else begin
      overrun_reg <= 1'b0;
      if (DMA_START) begin
        state_reg     <= ST_DMA;
        dma_cnt_reg   <= '0;
        ram_addr_reg  <= '0;
        dma_busy_reg  <= 1'b1;
        scan_busy_reg <= 1'b0;
        valid_reg     <= 1'b0;
      end else if (LINE_START && state_reg != ST_DMA) begin
        overrun_reg   <= (state_reg != ST_IDLE);
        line_reg      <= LINE_V;
        entry_reg     <= '0;
        rd_cnt_reg    <= '0;
        emit_cnt_reg  <= '0;
        full_reg      <= 1'b0;
        valid_reg     <= 1'b0;
        scan_busy_reg <= 1'b1;
        state_reg     <= ST_RD;
      end else begin
        case (state_reg)
          ST_DMA: begin
            dma_cnt_reg <= dma_cnt_reg + 10'd1;
            if (dma_cnt_reg < 10'd511) begin
              ram_addr_reg <= dma_cnt_reg[8:0] + 9'd1;
            end
            if (dma_cnt_reg == 10'd512) begin
              dma_busy_reg <= 1'b0;
              state_reg    <= ST_IDLE;
            end
          end
          ST_RD: begin
            if (rd_cnt_reg == 3'd4) begin
              rd_cnt_reg <= '0;
              state_reg  <= ST_EVAL;
            end else begin
              rd_cnt_reg <= rd_cnt_reg + 3'd1;
            end
          end
          ST_EVAL: begin
            if (hit_next) begin
              desc_reg  <= desc_next;
              valid_reg <= 1'b1;
              state_reg <= ST_EMIT;
            end else if (last_entry) begin
              scan_busy_reg <= 1'b0;
              state_reg     <= ST_IDLE;
            end else begin
              entry_reg <= entry_reg + 1'b1;
              state_reg <= ST_RD;
            end
          end
          ST_EMIT: begin
            if (OUT_READY) begin
              valid_reg    <= 1'b0;
              emit_cnt_reg <= emit_cnt_reg + 1'b1;
              if (emit_cnt_reg == CNT_W'(MAX_PER_LINE - 1)) begin
                full_reg      <= 1'b1;
                scan_busy_reg <= 1'b0;
                state_reg     <= ST_IDLE;
              end else if (last_entry) begin
                scan_busy_reg <= 1'b0;
                state_reg     <= ST_IDLE;
              end else begin
                entry_reg <= entry_reg + 1'b1;
                state_reg <= ST_RD;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign RAM_ADDR     = ram_addr_reg;
  assign DMA_BUSY     = dma_busy_reg;
  assign SCAN_BUSY    = scan_busy_reg;
  assign LINE_OVERRUN = overrun_reg;
  assign LINE_FULL    = full_reg;
  assign OUT_VALID    = valid_reg;
  assign OUT_CODE     = desc_reg.code;
  assign OUT_ROW      = desc_reg.row;
  assign OUT_X        = desc_reg.x;
  assign OUT_COLOR    = desc_reg.color;
  assign OUT_FLIPX    = desc_reg.flipx;

endmodule

// File: tb/tb_sprite_scan.sv
// Directed bench for sprite_scan: expected descriptors are queued by the stimulus
// and a negedge monitor pops and compares them on every handshake.
module tb_sprite_scan;

  logic        clk = 1'b0;
  logic        reset, dma_start, line_start;
  logic [8:0]  ram_addr, line_v;
  logic [15:0] ram_data;
  logic        dma_busy, scan_busy, line_overrun, line_full, out_valid, out_ready;
  logic [15:0] out_code;
  logic [3:0]  out_row, out_color;
  logic [9:0]  out_x;
  logic        out_flipx;

  logic        ready_man = 1'b1;
  logic        tog_en = 1'b0;
  logic        tog_reg = 1'b0;

  logic [15:0] cpu_mem [512];
  logic [34:0] exp_q [$];
  int          hs_count = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_data <= cpu_mem[ram_addr];
  always @(posedge clk) tog_reg <= ~tog_reg;
  assign out_ready = tog_en ? tog_reg : ready_man;

  sprite_scan dut (
    .CLK_32M      (clk),
    .RESET        (reset),
    .DMA_START    (dma_start),
    .RAM_ADDR     (ram_addr),
    .RAM_DATA     (ram_data),
    .DMA_BUSY     (dma_busy),
    .LINE_START   (line_start),
    .LINE_V       (line_v),
    .SCAN_BUSY    (scan_busy),
    .LINE_OVERRUN (line_overrun),
    .LINE_FULL    (line_full),
    .OUT_VALID    (out_valid),
    .OUT_READY    (out_ready),
    .OUT_CODE     (out_code),
    .OUT_ROW      (out_row),
    .OUT_X        (out_x),
    .OUT_COLOR    (out_color),
    .OUT_FLIPX    (out_flipx)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: scoreboard pop on handshake, stability check while stalled
  logic [34:0] cur_desc;
  logic [34:0] snap;
  logic        stall_prev = 1'b0;
  assign cur_desc = {out_code, out_row, out_x, out_color, out_flipx};

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_count++;
      $display("desc %0d: code=%h row=%0d x=%0d color=%0d flipx=%0b",
               hs_count, out_code, out_row, out_x, out_color, out_flipx);
      check("desc_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("desc_value", 64'(cur_desc), 64'(exp_q.pop_front()));
    end
    if (stall_prev && out_valid === 1'b1) check("stall_stable", 64'(cur_desc), 64'(snap));
    stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
    snap = cur_desc;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int i, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    cpu_mem[i*4 + 0] = w0;
    cpu_mem[i*4 + 1] = w1;
    cpu_mem[i*4 + 2] = w2;
    cpu_mem[i*4 + 3] = w3;
  endtask

  task automatic build_default;
    for (int i = 0; i < 128; i++) set_entry(i, 16'd300, 16'hFFFF, 16'h0000, 16'h0000);
  endtask

  task automatic run_dma;
    int k = 0;
    int bad = 0;
    step; dma_start = 1'b1;
    step; dma_start = 1'b0;
    check("dma_drops_valid", 64'(out_valid), 64'd0);
    while (dma_busy === 1'b1 && k < 1000) begin
      if (k < 512 && ram_addr !== 9'(k)) bad++;
      k++;
      step;
    end
    check("dma_busy_len", 64'(k), 64'd513);
    check("dma_addr_seq_errors", 64'(bad), 64'd0);
  endtask

  task automatic pulse_line(input logic [8:0] v);
    step; line_v = v; line_start = 1'b1;
    step; line_start = 1'b0;
  endtask

  task automatic run_line(input logic [8:0] v, output int k);
    k = 0;
    pulse_line(v);
    while (scan_busy === 1'b1 && k < 5000) begin
      k++;
      step;
    end
    check("scan_ended", 64'(scan_busy), 64'd0);
    step;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      k++;
      step;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hs0;
    int bad;
    reset = 1'b1; dma_start = 1'b0; line_start = 1'b0; line_v = '0;
    for (int n = 0; n < 512; n++) cpu_mem[n] = 16'(n) ^ 16'hA5A5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_dma_busy", 64'(dma_busy), 64'd0);
    check("rst_scan_busy", 64'(scan_busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_full", 64'(line_full), 64'd0);
    check("rst_overrun", 64'(line_overrun), 64'd0);
    check("rst_desc", 64'(cur_desc), 64'd0);
    reset = 1'b0;

    // DMA copy of the n ^ A5A5 pattern
    run_dma;
    bad = 0;
    for (int n = 0; n < 512; n++)
      if (dut.u_buf.u_ram.mem_reg[n] !== (16'(n) ^ 16'hA5A5)) bad++;
    check("buf_copy_errors", 64'(bad), 64'd0);

    // Basic hit on entry 3
    build_default;
    set_entry(3, 16'd100, 16'h1230, 16'h0005, 16'd200);
    run_dma;
    hs0 = hs_count;
    exp_q.push_back({16'h1230, 4'd7, 10'd200, 4'd5, 1'b0});
    run_line(9'd107, k);
    check("basic_scan_len", 64'(k), 64'd769);
    check("basic_hs", 64'(hs_count - hs0), 64'd1);

    // Flip-Y, two-tile sprite
    build_default;
    set_entry(5, 16'h1064, 16'h0040, 16'h0C09, 16'd17);
    run_dma;
    exp_q.push_back({16'h0041, 4'd12, 10'd17, 4'd9, 1'b1});
    run_line(9'd103, k);
    check("flip_scan_len", 64'(k), 64'd769);

    // Vertical wrap: Y=500, H=32
    build_default;
    set_entry(0, 16'h11F4, 16'h0100, 16'h0002, 16'd3);
    run_dma;
    exp_q.push_back({16'h0101, 4'd6, 10'd3, 4'd2, 1'b0});
    run_line(9'd10, k);
    check("wrap_hit_len", 64'(k), 64'd769);
    hs0 = hs_count;
    run_line(9'd20, k);
    check("wrap_miss_len", 64'(k), 64'd768);
    check("wrap_miss_hs", 64'(hs_count - hs0), 64'd0);

    // Every entry hits: limit and backpressure
    for (int i = 0; i < 128; i++)
      set_entry(i, 16'h3000, 16'(i * 16), 16'(i % 16) | (16'(i % 2) << 10), 16'(i));
    run_dma;
    for (int i = 0; i < 32; i++)
      exp_q.push_back({16'(i * 16 + 3), 4'd2, 10'(i), 4'(i % 16), 1'(i % 2)});
    hs0 = hs_count;
    tog_en = 1'b1;
    run_line(9'd50, k);
    tog_en = 1'b0;
    check("limit_hs", 64'(hs_count - hs0), 64'd32);
    check("limit_full", 64'(line_full), 64'd1);

    // Overrun while stalled, then DMA abort
    ready_man = 1'b0;
    pulse_line(9'd50);
    check("full_cleared", 64'(line_full), 64'd0);
    check("scan_busy_set", 64'(scan_busy), 64'd1);
    wait_valid("stall_valid_a");
    exp_q.push_back({16'h0003, 4'd12, 10'd0, 4'd0, 1'b0});
    pulse_line(9'd60);
    check("overrun_pulse", 64'(line_overrun), 64'd1);
    check("overrun_drops_valid", 64'(out_valid), 64'd0);
    step;
    check("overrun_one_cycle", 64'(line_overrun), 64'd0);
    hs0 = hs_count;
    ready_man = 1'b1;
    k = 0;
    while (hs_count == hs0 && k < 100) begin
      k++;
      step;
    end
    ready_man = 1'b0;
    check("restart_hs", 64'(hs_count - hs0), 64'd1);
    wait_valid("stall_valid_b");
    run_dma;
    check("dma_abort_scan_idle", 64'(scan_busy), 64'd0);
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-scan
    pulse_line(9'd50);
    wait_valid("stall_valid_c");
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_scan_busy", 64'(scan_busy), 64'd0);

    // Simultaneous DMA_START and LINE_START, then LINE_START during DMA
    step; dma_start = 1'b1; line_start = 1'b1; line_v = 9'd50;
    step; dma_start = 1'b0; line_start = 1'b0;
    check("simul_dma_busy", 64'(dma_busy), 64'd1);
    check("simul_scan_busy", 64'(scan_busy), 64'd0);
    repeat (5) step;
    pulse_line(9'd50);
    check("dma_line_no_overrun", 64'(line_overrun), 64'd0);
    check("dma_line_no_scan", 64'(scan_busy), 64'd0);
    k = 0;
    while (dma_busy === 1'b1 && k < 1000) begin
      k++;
      step;
    end
    check("simul_dma_done", 64'(dma_busy), 64'd0);
    check("simul_final_scan_idle", 64'(scan_busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sprite_scan.md
Name: sprite_scan

Overview:
- Read-side counterpart of the CPU-written sprite RAM (512 x 16, 128 entries x 4 words).
- On a DMA request, copies the whole RAM into a private sprite buffer. The CPU may then rewrite its RAM freely.
- On each line request, scans the buffer for sprites that intersect the requested line. Each hit is emitted as a descriptor over a valid/ready handshake to the line drawer.

Parameters:
- NUM_ENTRIES, 128, sprite entries scanned per line (4 words each, buffer depth 4*NUM_ENTRIES).
- MAX_PER_LINE, 32, maximum descriptors emitted per line; the scan stops after this many.

Ports:
- CLK_32M  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- DMA_START  in  1  one-cycle pulse: start copying the CPU sprite RAM.
- RAM_ADDR  out  9  word address into the CPU sprite RAM read port.
- RAM_DATA  in  16  read data; valid exactly 1 cycle after RAM_ADDR.
- DMA_BUSY  out  1  high while a copy is in progress.
- LINE_START  in  1  one-cycle pulse: scan for line LINE_V.
- LINE_V  in  9  target line; sampled on LINE_START.
- SCAN_BUSY  out  1  high from LINE_START until the scan ends.
- LINE_OVERRUN  out  1  one-cycle pulse: LINE_START arrived while a scan was busy.
- LINE_FULL  out  1  set when MAX_PER_LINE is reached; cleared on the next LINE_START.
- OUT_VALID  out  1  descriptor valid.
- OUT_READY  in  1  drawer accepts the descriptor.
- OUT_CODE  out  16  tile code, adjusted for the vertical tile within the sprite.
- OUT_ROW  out  4  pixel row within the 16-pixel tile.
- OUT_X  out  10  sprite X.
- OUT_COLOR  out  4  palette.
- OUT_FLIPX  out  1  horizontal flip.

Behaviour:
- Entry format:
  - w0: [8:0] Y, [13:12] hc, where height H = 16 << hc.
  - w1: code.
  - w2: [3:0] color, [10] flipx, [11] flipy.
  - w3: [9:0] X.
- Reset:
  - State IDLE.
  - All outputs 0; RAM_ADDR = 0.
  - Buffer contents are not cleared.
- States: IDLE, DMA, RD (4 reads), EVAL, EMIT.
- DMA:
  - From any state, DMA_START enters DMA and aborts any scan; OUT_VALID drops the next cycle.
  - RAM_ADDR counts 0..511, one per cycle. Word n is written to the buffer at n on the cycle after its address.
  - DMA_BUSY is high for 513 cycles, then the block returns to IDLE.
  - A DMA_START during DMA restarts the copy at 0.
  - LINE_START is ignored during DMA, with no overrun pulse.
- Scan start:
  - LINE_START in IDLE latches LINE_V and enters RD with entry index 0.
  - The buffer read has 1-cycle latency. RD fetches w0..w3 in 5 cycles (4 addresses plus the trailing data cycle), then the block moves to EVAL.
- EVAL:
  - dy = (V - Y) mod 512, 9-bit wrap.
  - Hit iff dy < H. Y = 500, H = 32 hits V = 500..511 and 0..19.
  - row = flipy ? H-1-dy : dy.
  - OUT_CODE = code + row[6:4], 16-bit wrap. OUT_ROW = row[3:0].
  - Hit: go to EMIT. Miss: next entry.
- EMIT:
  - Outputs are held stable while OUT_VALID && !OUT_READY.
  - On handshake: emitted count +1. If count == MAX_PER_LINE, set LINE_FULL and end the scan; otherwise go to the next entry.
- End of scan: after entry NUM_ENTRIES-1 the block returns to IDLE and SCAN_BUSY drops.
- Zero-stall throughput: a miss takes 6 cycles per entry; a hit with OUT_READY=1 takes 7.
- Scan overrun: LINE_START while SCAN_BUSY (RD/EVAL/EMIT) pulses LINE_OVERRUN, drops OUT_VALID, and restarts the scan at entry 0 with the new LINE_V. The emitted count resets.
- Simultaneous DMA_START and LINE_START: DMA wins.
- RESET mid-operation returns to IDLE within one cycle.

Decomposition:
- Package sprite_pkg holds:
  - entry word offsets and field bit positions;
  - hc-to-height function;
  - descriptor struct (code, row, x, color, flipx).
- One natural sub-module: sprite_buf, a 512x16 single-clock buffer RAM with 1-cycle read latency, built on dpramv.
  - Port A: DMA write.
  - Port B: scan read.

Test Plan:
- DMA: fill CPU RAM with word n = n ^ 0xA5A5, pulse DMA_START -> DMA_BUSY high 513 cycles; RAM_ADDR sequence 0..511; buffer word n = n ^ 0xA5A5.
- Basic hit: entry 3 = {Y=100, hc=0, code=0x1230, color=5, X=200}, others Y=300. LINE_V=107 -> one descriptor {code 0x1230, row 7, X 200, color 5}, then SCAN_BUSY falls.
- Flip and multi-tile: hc=1, flipy=1, Y=100, code=0x0040. LINE_V=103 -> row=28, OUT_CODE=0x0041, OUT_ROW=12.
- Wrap: Y=500, hc=1. LINE_V=10 -> hit with dy=22. LINE_V=20 -> no descriptor.
- Backpressure and limit: all 128 entries hit, OUT_READY toggling 1/0. Exactly 32 handshakes occur, outputs stay stable while stalled, and LINE_FULL=1.
- Abort: LINE_START mid-scan -> LINE_OVERRUN pulse, restart. DMA_START mid-scan -> OUT_VALID=0 next cycle, DMA runs to completion.
